therm_code_encoder: RTL

- Readback encoder for the delay-line control path: converts the coarse 16-bit and two fine 8-bit complementary thermometer words driven into the delay line back into a 10-bit binary code.
- Synchronises the words into the clk_ext domain and filters them for stability.
- Checks thermometer and complement integrity, and compares the result against the code the SAR intended.
- Used for lock verification and for diagnostic readout of the delay setting.

---
 rtl/ptc_pkg.sv | 16 +
 rtl/therm_decode.sv | 57 +++++
 rtl/therm_code_encoder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ptc_pkg.sv
// Shared widths and filter state encoding for the thermometer readback encoder.
package ptc_pkg;

    localparam int COARSE_W  = 4;
    localparam int FINE_W    = 3;
    localparam int CODE_W    = 10;
    localparam int THERM_C_W = 16;
    localparam int THERM_F_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/therm_decode.sv
// Combinational decoder for one thermometer word.
// Build option THERM_BUBBLE_CORRECT_EN: value becomes the population count of
// the lower W-1 bits, so a single bubble still yields a usable value.
module therm_decode #(
    parameter int W  = 8,
    parameter int VW = $clog2(W)
) (
    input  logic [W-1:0]  therm,
    output logic [VW-1:0] value,
    output logic          bubble,
    output logic          topbit_err
);

    genvar gi;

    // A one sitting directly above a zero anywhere in the word is a bubble.
    logic [W-2:0] w_rise;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_rise
            assign w_rise[gi] = therm[gi + 1] & ~therm[gi];
        end
    endgenerate

    assign bubble     = |w_rise;
    assign topbit_err = therm[W-1];

`ifdef THERM_BUBBLE_CORRECT_EN
    // Value counts every set bit below the top bit.
    always_comb begin
        value = '0;
        for (int i = 0; i < W - 1; i++) begin
            value = value + VW'(therm[i]);
        end
    end
`else
    // w_run[gi] stays high only while every bit from 0 up to gi is set.
    logic [W-2:0] w_run;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_run
            if (gi == 0) begin : g_first
                assign w_run[gi] = therm[0];
            end else begin : g_next
                assign w_run[gi] = w_run[gi - 1] & therm[gi];
            end
        end
    endgenerate

    // Value is the length of the unbroken run of ones from bit 0.
    always_comb begin
        value = '0;
        for (int i = 0; i < W - 1; i++) begin
            value = value + VW'(w_run[i]);
        end
    end
`endif

endmodule

// File: rtl/therm_code_encoder.sv
// Thermometer readback encoder: synchronises the coarse/fine thermometer and
// complement words into clk_ext, decodes them to a 10-bit code, filters the
// code for stability and flags thermometer and complement integrity errors.
// Build option THERM_BUBBLE_CORRECT_EN: bubbles are corrected by population
// count and the err_cnt output counts corrected samples.
module therm_code_encoder
    import ptc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4
) (
    input  logic                 clk_ext,
    input  logic                 rst_n,
    input  logic [THERM_C_W-1:0] T,
    input  logic [THERM_C_W-1:0] Tb,
    input  logic [THERM_F_W-1:0] T_f1,
    input  logic [THERM_F_W-1:0] Tb_f1,
    input  logic [THERM_F_W-1:0] T_f2,
    input  logic [THERM_F_W-1:0] Tb_f2,
    input  logic [CODE_W-1:0]    Q_ref,
    input  logic                 clr_err,
`ifdef THERM_BUBBLE_CORRECT_EN
    output logic [7:0]           err_cnt,
`endif
    output logic [CODE_W-1:0]    code_out,
    output logic                 code_valid,
    output logic                 code_chg,
    output logic                 match,
    output logic                 therm_err,
    output logic                 comp_err
);

    localparam int SYNC_W = 2 * THERM_C_W + 4 * THERM_F_W;
    localparam int CNT_W  = 4;

    genvar gi;

    // ---------------- synchroniser ----------------
    // Top bit of each stage is a sample-valid marker so that the reset zeros
    // flushing out of the chain are never decoded as real samples.
    logic [SYNC_W:0] r_sync [SYNC_STAGES];
    logic [SYNC_W:0] w_sync_in;

    assign w_sync_in = {1'b1, T, Tb, T_f1, Tb_f1, T_f2, Tb_f2};

    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            // Shift the raw words one stage further into clk_ext.
            always_ff @(posedge clk_ext or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync[gi] <= '0;
                end else if (gi == 0) begin
                    r_sync[gi] <= w_sync_in;
                end else begin
                    r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic                 w_s_vld;
    logic [THERM_C_W-1:0] w_s_t, w_s_tb;
    logic [THERM_F_W-1:0] w_s_t1, w_s_tb1, w_s_t2, w_s_tb2;

    assign {w_s_vld, w_s_t, w_s_tb, w_s_t1, w_s_tb1, w_s_t2, w_s_tb2} = r_sync[SYNC_STAGES-1];

    // ---------------- decode ----------------
    logic [COARSE_W-1:0] w_val_c;
    logic [FINE_W-1:0]   w_val_f1, w_val_f2;
    logic                w_bub_c, w_bub_f1, w_bub_f2;
    logic                w_top_c, w_top_f1, w_top_f2;

    therm_decode #(.W(THERM_C_W)) u_dec_c (
        .therm(w_s_t), .value(w_val_c), .bubble(w_bub_c), .topbit_err(w_top_c)
    );
    therm_decode #(.W(THERM_F_W)) u_dec_f1 (
        .therm(w_s_t1), .value(w_val_f1), .bubble(w_bub_f1), .topbit_err(w_top_f1)
    );
    therm_decode #(.W(THERM_F_W)) u_dec_f2 (
        .therm(w_s_t2), .value(w_val_f2), .bubble(w_bub_f2), .topbit_err(w_top_f2)
    );

    logic w_therm_bad;
    logic w_comp_bad;
    logic w_sample_bad;

    assign w_therm_bad = w_bub_c | w_bub_f1 | w_bub_f2 | w_top_c | w_top_f1 | w_top_f2;
    assign w_comp_bad  = (w_s_tb != ~w_s_t) | (w_s_tb1 != ~w_s_t1) | (w_s_tb2 != ~w_s_t2);
`ifdef THERM_BUBBLE_CORRECT_EN
    assign w_sample_bad = 1'b0;
`else
    assign w_sample_bad = w_therm_bad;
`endif

    logic              r_dec_vld;
    logic              r_dec_bad;
    logic              r_dec_therm;
    logic              r_dec_comp;
    logic [CODE_W-1:0] r_dec_code;

    // Register the decoded code and its integrity flags.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_vld   <= 1'b0;
            r_dec_bad   <= 1'b0;
            r_dec_therm <= 1'b0;
            r_dec_comp  <= 1'b0;
            r_dec_code  <= '0;
        end else begin
            r_dec_vld   <= w_s_vld;
            r_dec_bad   <= w_s_vld & w_sample_bad;
            r_dec_therm <= w_s_vld & w_therm_bad;
            r_dec_comp  <= w_s_vld & w_comp_bad;
            r_dec_code  <= {w_val_c, w_val_f1, w_val_f2};
        end
    end

    // ---------------- stability filter ----------------
    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [CODE_W-1:0] r_prev, w_prev_next;
    logic [CODE_W-1:0] r_code, w_code_next;
    logic              r_valid, w_valid_next;
    logic              r_chg, w_chg_next;
    logic              w_good;

    assign w_good = r_dec_vld & ~r_dec_bad;

    // Filter state and output registers.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_prev  <= w_prev_next;
            r_code  <= w_code_next;
            r_valid <= w_valid_next;
            r_chg   <= w_chg_next;
        end
    end

    // Count consecutive identical good samples; load code_out once the count
    // reaches STABLE_CNT. Bad samples leave everything untouched.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_prev_next  = r_prev;
        w_code_next  = r_code;
        w_valid_next = r_valid;
        w_chg_next   = 1'b0;
        if (w_good) begin
            case (r_state)
                IDLE: begin
                    w_state_next = SETTLE;
                    w_cnt_next   = CNT_W'(1);
                    w_prev_next  = r_dec_code;
                end
                SETTLE: begin
                    w_prev_next = r_dec_code;
                    w_cnt_next  = (r_dec_code == r_prev) ? r_cnt + CNT_W'(1) : CNT_W'(1);
                end
                LOCKED: begin
                    if (r_dec_code != r_code) begin
                        w_state_next = SETTLE;
                        w_cnt_next   = CNT_W'(1);
                        w_prev_next  = r_dec_code;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
            if (w_state_next == SETTLE && w_cnt_next == CNT_W'(STABLE_CNT)) begin
                w_state_next = LOCKED;
                w_code_next  = r_dec_code;
                w_valid_next = 1'b1;
                w_chg_next   = ~r_valid | (r_dec_code != r_code);
            end
        end
    end

    // ---------------- sticky error flags ----------------
    logic r_therm_err;
    logic r_comp_err;

    // A new error on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_therm_err <= 1'b0;
            r_comp_err  <= 1'b0;
        end else begin
            r_therm_err <= (r_therm_err & ~clr_err) | r_dec_therm;
            r_comp_err  <= (r_comp_err & ~clr_err) | r_dec_comp;
        end
    end

`ifdef THERM_BUBBLE_CORRECT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of samples accepted despite a thermometer error.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_dec_therm) begin
            r_err_cnt <= clr_err ? 8'd1 : ((r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1);
        end else if (clr_err) begin
            r_err_cnt <= '0;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign code_chg   = r_chg;
    assign therm_err  = r_therm_err;
    assign comp_err   = r_comp_err;
    assign match      = r_valid & (r_code == Q_ref);

endmodule
